// File: rtl/hazard_pkg.sv
// hazard_pkg: shared forwarding codes, Tnew constants and saturating decrement
package hazard_pkg;
  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;
  localparam logic [1:0] TNEW_NONE = 2'd0;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;
  // Tnew counts down to 0 and then holds there; it never wraps.
  function automatic logic [7:0] sat_dec(input logic [7:0] x);
    return (x == 8'd0) ? 8'd0 : x - 8'd1;
  endfunction
endpackage

// File: rtl/hazard_stage_reg.sv
// hazard_stage_reg: one pipeline slot holding a payload and its Tnew, with bubble and decrement
module hazard_stage_reg import hazard_pkg::*; #(
  parameter int PW = 5,
  parameter int TW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          bubble_i,
  input  logic          dec_i,
  input  logic [PW-1:0] pay_i,
  input  logic [TW-1:0] tnew_i,
  output logic [PW-1:0] pay_o,
  output logic [TW-1:0] tnew_o
);
  logic [PW-1:0] pay_q, pay_d;
  logic [TW-1:0] tnew_q, tnew_d;
  // A bubble clears the whole slot; otherwise take the upstream value, aged by one cycle if asked.
  always_comb begin
    pay_d  = bubble_i ? '0 : pay_i;
    tnew_d = bubble_i ? '0 : dec_i ? TW'(sat_dec(8'(tnew_i))) : tnew_i;
  end
  // Slot register, cleared immediately on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pay_q  <= '0;
      tnew_q <= '0;
    end else begin
      pay_q  <= pay_d;
      tnew_q <= tnew_d;
    end
  end
  assign pay_o  = pay_q;
  assign tnew_o = tnew_q;
endmodule

// File: rtl/hazard_tracker.sv
// hazard_tracker: tracks E/M/W destinations and Tnew, and derives D/E forwarding selects
module hazard_tracker import hazard_pkg::*; #(
  parameter int ADDR_W = 5,
  parameter int TNEW_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_en,
  input  logic [ADDR_W-1:0] D_rs,
  input  logic [ADDR_W-1:0] D_rt,
  input  logic [ADDR_W-1:0] D_A3,
  input  logic [TNEW_W-1:0] D_Tnew,
  output logic [TNEW_W-1:0] E_Tnew,
  output logic [TNEW_W-1:0] M_Tnew,
  output logic [TNEW_W-1:0] W_Tnew,
  output logic [ADDR_W-1:0] E_A3,
  output logic [ADDR_W-1:0] M_A3,
  output logic [ADDR_W-1:0] W_A3,
  output logic [1:0]        D_fwd_rs,
  output logic [1:0]        D_fwd_rt,
  output logic [1:0]        E_fwd_rs,
  output logic [1:0]        E_fwd_rt
);
  logic [3*ADDR_W-1:0] e_pay;
  logic [ADDR_W-1:0]   e_rs, e_rt;

  hazard_stage_reg #(.PW(3*ADDR_W), .TW(TNEW_W)) u_e (
    .clk(clk), .reset(reset), .bubble_i(stall_en), .dec_i(1'b0),
    .pay_i({D_A3, D_rs, D_rt}), .tnew_i(D_Tnew), .pay_o(e_pay), .tnew_o(E_Tnew)
  );
  hazard_stage_reg #(.PW(ADDR_W), .TW(TNEW_W)) u_m (
    .clk(clk), .reset(reset), .bubble_i(1'b0), .dec_i(1'b1),
    .pay_i(E_A3), .tnew_i(E_Tnew), .pay_o(M_A3), .tnew_o(M_Tnew)
  );
  hazard_stage_reg #(.PW(ADDR_W), .TW(TNEW_W)) u_w (
    .clk(clk), .reset(reset), .bubble_i(1'b0), .dec_i(1'b1),
    .pay_i(M_A3), .tnew_i(M_Tnew), .pay_o(W_A3), .tnew_o(W_Tnew)
  );

  assign {E_A3, e_rs, e_rt} = e_pay;

  // A matching stage decides the select: forward if ready, else regfile (stall covers it); no match defers to older.
  function automatic logic [1:0] sel(input logic [ADDR_W-1:0] r, input logic [ADDR_W-1:0] a3,
                                     input logic [TNEW_W-1:0] tnew, input logic [1:0] code,
                                     input logic [1:0] older);
    return (r != '0 && a3 == r) ? ((tnew == '0) ? code : FWD_RF) : older;
  endfunction

  // Youngest-first forwarding selects for the D operands and the registered E operands.
  always_comb begin
    D_fwd_rs = sel(D_rs, E_A3, E_Tnew, FWD_E, sel(D_rs, M_A3, M_Tnew, FWD_M, sel(D_rs, W_A3, W_Tnew, FWD_W, FWD_RF)));
    D_fwd_rt = sel(D_rt, E_A3, E_Tnew, FWD_E, sel(D_rt, M_A3, M_Tnew, FWD_M, sel(D_rt, W_A3, W_Tnew, FWD_W, FWD_RF)));
    E_fwd_rs = sel(e_rs, M_A3, M_Tnew, FWD_M, sel(e_rs, W_A3, W_Tnew, FWD_W, FWD_RF));
    E_fwd_rt = sel(e_rt, M_A3, M_Tnew, FWD_M, sel(e_rt, W_A3, W_Tnew, FWD_W, FWD_RF));
  end
endmodule

// File: tb/tb_hazard_tracker.sv
// tb_hazard_tracker: directed and random checks of hazard_tracker against an issue-history model
module tb_hazard_tracker;
  logic       clk = 0, reset = 1, stall_en = 0;
  logic [4:0] D_rs = 0, D_rt = 0, D_A3 = 0;
  logic [1:0] D_Tnew = 0;
  logic [1:0] E_Tnew, M_Tnew, W_Tnew, D_fwd_rs, D_fwd_rt, E_fwd_rs, E_fwd_rt;
  logic [4:0] E_A3, M_A3, W_A3;
  int n_cmp = 0, n_bad = 0;
  // model: the instruction issued k cycles ago (k=0 is E); stored with its issue-time Tnew
  logic [4:0] m_a3[3], m_rs[3], m_rt[3];
  int         m_t[3];

  hazard_tracker dut (
    .clk(clk), .reset(reset), .stall_en(stall_en), .D_rs(D_rs), .D_rt(D_rt), .D_A3(D_A3),
    .D_Tnew(D_Tnew), .E_Tnew(E_Tnew), .M_Tnew(M_Tnew), .W_Tnew(W_Tnew), .E_A3(E_A3),
    .M_A3(M_A3), .W_A3(W_A3), .D_fwd_rs(D_fwd_rs), .D_fwd_rt(D_fwd_rt), .E_fwd_rs(E_fwd_rs),
    .E_fwd_rt(E_fwd_rt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // remaining Tnew of the instruction k stages past E: issue Tnew minus age, floored at 0
  function automatic int tn(input int k);
    return (m_t[k] > k) ? m_t[k] - k : 0;
  endfunction

  // first stage (from 'first', youngest first) naming r decides; code is stage index + 1
  function automatic logic [1:0] mfwd(input logic [4:0] r, input int first);
    for (int k = first; k < 3; k++)
      if (r != 0 && m_a3[k] == r) return (tn(k) == 0) ? 2'(k + 1) : 2'd0;
    return 2'd0;
  endfunction

  task automatic clear_model();
    for (int k = 0; k < 3; k++) begin
      m_a3[k] = 0; m_rs[k] = 0; m_rt[k] = 0; m_t[k] = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) clear_model();
    else begin
      for (int k = 2; k > 0; k--) begin
        m_a3[k] = m_a3[k-1]; m_rs[k] = m_rs[k-1]; m_rt[k] = m_rt[k-1]; m_t[k] = m_t[k-1];
      end
      m_a3[0] = stall_en ? 5'd0 : D_A3;
      m_rs[0] = stall_en ? 5'd0 : D_rs;
      m_rt[0] = stall_en ? 5'd0 : D_rt;
      m_t[0]  = stall_en ? 0 : int'(D_Tnew);
    end
    #1;
  endtask

  task automatic drive(input logic [4:0] a3, input logic [1:0] t, input logic [4:0] rs,
                       input logic [4:0] rt, input logic st);
    D_A3 = a3; D_Tnew = t; D_rs = rs; D_rt = rt; stall_en = st;
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".E_A3"}, 8'(E_A3), 8'(m_a3[0]));
    chk({tag, ".M_A3"}, 8'(M_A3), 8'(m_a3[1]));
    chk({tag, ".W_A3"}, 8'(W_A3), 8'(m_a3[2]));
    chk({tag, ".E_Tnew"}, 8'(E_Tnew), 8'(tn(0)));
    chk({tag, ".M_Tnew"}, 8'(M_Tnew), 8'(tn(1)));
    chk({tag, ".W_Tnew"}, 8'(W_Tnew), 8'(tn(2)));
    chk({tag, ".D_fwd_rs"}, 8'(D_fwd_rs), 8'(mfwd(D_rs, 0)));
    chk({tag, ".D_fwd_rt"}, 8'(D_fwd_rt), 8'(mfwd(D_rt, 0)));
    chk({tag, ".E_fwd_rs"}, 8'(E_fwd_rs), 8'(mfwd(m_rs[0], 1)));
    chk({tag, ".E_fwd_rt"}, 8'(E_fwd_rt), 8'(mfwd(m_rt[0], 1)));
  endtask

  initial begin
    clear_model();
    tick();
    tick();
    reset = 0;
    #1;
    check_all("reset");
    // ALU chain
    drive(8, 1, 0, 0, 0);
    tick();
    drive(0, 0, 8, 0, 0);
    check_all("alu1");
    chk("alu1.E_Tnew_const", 8'(E_Tnew), 8'd1);
    chk("alu1.D_fwd_rs_const", 8'(D_fwd_rs), 8'd0);
    tick();
    check_all("alu2");
    chk("alu2.M_Tnew_const", 8'(M_Tnew), 8'd0);
    chk("alu2.D_fwd_rs_const", 8'(D_fwd_rs), 8'd2);
    chk("alu2.E_fwd_rs_const", 8'(E_fwd_rs), 8'd2);
    // load-use with one stall
    drive(9, 2, 0, 0, 0);
    tick();
    drive(0, 0, 0, 9, 1);
    check_all("lu1");
    chk("lu1.E_Tnew_const", 8'(E_Tnew), 8'd2);
    chk("lu1.D_fwd_rt_const", 8'(D_fwd_rt), 8'd0);
    tick();
    drive(0, 0, 0, 9, 0);
    check_all("lu2");
    chk("lu2.E_A3_const", 8'(E_A3), 8'd0);
    chk("lu2.E_Tnew_const", 8'(E_Tnew), 8'd0);
    chk("lu2.M_A3_const", 8'(M_A3), 8'd9);
    chk("lu2.M_Tnew_const", 8'(M_Tnew), 8'd1);
    tick();
    check_all("lu3");
    chk("lu3.W_A3_const", 8'(W_A3), 8'd9);
    chk("lu3.W_Tnew_const", 8'(W_Tnew), 8'd0);
    chk("lu3.D_fwd_rt_const", 8'(D_fwd_rt), 8'd3);
    // priority: all three stages name r5
    drive(5, 0, 0, 0, 0);
    tick();
    tick();
    tick();
    drive(0, 0, 5, 0, 0);
    check_all("prio1");
    chk("prio1.D_fwd_rs_const", 8'(D_fwd_rs), 8'd1);
    drive(5, 1, 0, 0, 0);
    tick();
    drive(0, 0, 5, 0, 0);
    check_all("prio2");
    chk("prio2.D_fwd_rs_const", 8'(D_fwd_rs), 8'd0);
    // zero register never forwarded
    drive(0, 0, 0, 0, 0);
    tick();
    check_all("zero");
    chk("zero.D_fwd_rs_const", 8'(D_fwd_rs), 8'd0);
    // saturation: Tnew 0 stays 0 down the pipe
    drive(3, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all("sat");
      chk("sat.W_Tnew_const", 8'(W_Tnew), 8'd0);
    end
    // asynchronous reset mid-stream
    drive(8, 1, 0, 0, 0);
    tick();
    drive(7, 2, 0, 0, 0);
    tick();
    chk("pre_rst.E_Tnew", 8'(E_Tnew), 8'd2);
    chk("pre_rst.M_A3", 8'(M_A3), 8'd8);
    reset = 1;
    stall_en = 1;
    #1;
    clear_model();
    D_rs = 0; D_rt = 0;
    #1;
    check_all("arst");
    tick();
    check_all("arst_hold");
    reset = 0;
    // random traffic over a small register set to provoke matches
    for (int i = 0; i < 400; i++) begin
      drive(5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0));
      check_all("rand");
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
